// File: rtl/cache_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cache_bus_arbiter
//  Purpose  : Shares one SRAM-like memory port between the instruction and
//             data caches, one transaction outstanding at a time.
//             Define ARB_ROUND_ROBIN_EN to alternate grants when both sides
//             request together; otherwise the data side has fixed priority.
//  Revision : 1.0  initial release
// ============================================================================
module cache_bus_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction-side requester
    input  logic                  i_req,
    input  logic                  i_wr,
    input  logic [1:0]            i_size,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           i_rdata,
    output logic                  i_addr_ok,
    output logic                  i_data_ok,
    // data-side requester
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [1:0]            d_size,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic [31:0]           d_rdata,
    output logic                  d_addr_ok,
    output logic                  d_data_ok,
    // shared memory port
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [1:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   owner;       // 0 = instruction side, 1 = data side
    logic   owner_nxt;
    logic   grant_d;     // arbitration result while idle
    logic   addr_ok;     // owner's address handshake this cycle
    logic   data_ok;     // owner's completion this cycle

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;    // side granted most recently

    // Contention goes to the side that was not granted last time
    always_comb begin
        grant_d = d_req;
        if (i_req && d_req) begin
            grant_d = ~last_grant;
        end
    end

    // Remember every grant so the next contention alternates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b0;
        end else if (state == ST_IDLE && (i_req || d_req)) begin
            last_grant <= grant_d;
        end
    end
`else
    // Fixed priority: the data side wins whenever it requests
    assign grant_d = d_req;
`endif

    // State and owner registers; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            owner <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // Next-state logic and handshake generation
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        mem_req   = 1'b0;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        case (state)
            ST_IDLE: begin
                // memory handshakes are ignored here on purpose
                if (i_req || d_req) begin
                    owner_nxt = grant_d;
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                mem_req = 1'b1;
                if (mem_addr_ok) begin
                    addr_ok = 1'b1;
                    if (mem_data_ok) begin
                        data_ok   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (mem_data_ok) begin
                    data_ok   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request fields follow the current owner's live inputs
    assign mem_wr    = owner ? d_wr    : i_wr;
    assign mem_size  = owner ? d_size  : i_size;
    assign mem_addr  = owner ? d_addr  : i_addr;
    assign mem_wdata = owner ? d_wdata : i_wdata;

    // Handshakes go only to the owner; read data is broadcast
    assign i_addr_ok = addr_ok & ~owner;
    assign i_data_ok = data_ok & ~owner;
    assign d_addr_ok = addr_ok &  owner;
    assign d_data_ok = data_ok &  owner;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule
`default_nettype wire
